// File: rtl/vm3_qbus_slave.sv
// QBUS slave sequencer for the 1801VM3 board: RAM, halt control, outhex and terminal registers.
// Terminal registers, TX busy timer and the vectored interrupt exist only with VM3_QBUS_SLAVE_TTY_EN.
module vm3_qbus_slave #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [15:0] RAM_TOP     = 16'o100000,
   parameter logic [15:0] TTY_VECTOR  = 16'o000064,
   parameter int unsigned TX_DELAY    = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sync,
   input  logic        din,
   input  logic        dout,
   input  logic        wtbt,
   input  logic        iako,
   input  logic [15:0] ad_in,
   output logic [15:0] ad_out,
   output logic        ad_oe,
   output logic        rply,
   output logic        virq,
   output logic [13:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [1:0]  mem_be,
   input  logic [15:0] mem_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_stb,
   output logic        halt_rq,
   output logic        evnt_rq,
   output logic        halt_en,
   output logic [15:0] hex_out
);

`ifdef VM3_QBUS_SLAVE_TTY_EN
   localparam bit TtyEn = 1'b1;
`else
   localparam bit TtyEn = 1'b0;
`endif

   localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
   localparam logic [15:0] TxInit   = 16'(TX_DELAY);
   localparam bit          TxZero   = (TX_DELAY == 0);

   localparam logic [15:0] AdrRcsr = 16'o177560;
   localparam logic [15:0] AdrRbuf = 16'o177562;
   localparam logic [15:0] AdrXcsr = 16'o177564;
   localparam logic [15:0] AdrXbuf = 16'o177566;
   localparam logic [15:0] AdrHalt = 16'o177710;
   localparam logic [15:0] AdrHex  = 16'o177714;
   localparam logic [15:0] AdrSys  = 16'o177716;

   typedef enum logic [2:0] {StIdle, StAddr, StWait, StReply, StVec} state_e;

   state_e      state_q, state_d;
   logic        sync_q, din_q, dout_q;
   logic [15:0] addr_q, addr_d;
   logic        byte_q, byte_d;
   logic        write_q, write_d;
   logic        vec_q, vec_d;
   logic [3:0]  wait_q, wait_d;
   logic        mem_rd_q, mem_rd_d, rd_valid_q;
   logic        mem_wr_q, mem_wr_d;
   logic [15:0] rdata_q, rdata_d;
   logic        go_reply, wr_fire;

   logic        halt_rq_q, evnt_rq_q, halt_en_q;
   logic [15:0] hex_q;
   logic        rx_ie_q, tx_ie_q, tx_rdy_q, vec_taken_q, tx_stb_q;
   logic [7:0]  tx_data_q;
   logic [15:0] busy_q;

   logic [15:0] addr_w, wmask, reg_rdata;
   logic [1:0]  be;
   logic        sel_ram, sel_rcsr, sel_rbuf, sel_xcsr, sel_xbuf, sel_halt, sel_hex, sel_sys, sel;

   assign addr_w   = {addr_q[15:1], 1'b0};
   assign sel_ram  = addr_q < RAM_TOP;
   assign sel_rcsr = TtyEn && (addr_w == AdrRcsr);
   assign sel_rbuf = TtyEn && (addr_w == AdrRbuf);
   assign sel_xcsr = TtyEn && (addr_w == AdrXcsr);
   assign sel_xbuf = TtyEn && (addr_w == AdrXbuf);
   assign sel_halt = addr_w == AdrHalt;
   assign sel_hex  = addr_w == AdrHex;
   assign sel_sys  = addr_w == AdrSys;
   assign sel      = sel_ram | sel_rcsr | sel_rbuf | sel_xcsr | sel_xbuf | sel_halt | sel_hex | sel_sys;

   // Byte cycles touch only the lane picked by address bit 0.
   assign wmask = !byte_q ? 16'hFFFF : (addr_q[0] ? 16'hFF00 : 16'h00FF);
   assign be    = !byte_q ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);

   always_comb begin
      reg_rdata = 16'h0000;
      if (sel_rcsr) reg_rdata[6] = rx_ie_q;
      if (sel_xcsr) begin
         reg_rdata[7] = tx_rdy_q;
         reg_rdata[6] = tx_ie_q;
      end
      if (sel_halt) reg_rdata = {halt_en_q, 13'h0000, evnt_rq_q, halt_rq_q};
      if (sel_hex)  reg_rdata = hex_q;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      byte_d   = byte_q;
      write_d  = write_q;
      vec_d    = vec_q;
      wait_d   = wait_q;
      mem_rd_d = 1'b0;
      go_reply = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sync && !sync_q) begin
               state_d = StAddr;
               addr_d  = ad_in;
               byte_d  = wtbt;
               vec_d   = 1'b0;
            end else if (din && !din_q && iako && virq) begin
               state_d = StWait;
               vec_d   = 1'b1;
               write_d = 1'b0;
               wait_d  = WaitInit;
            end
         end
         StAddr: begin
            if (!sync) begin
               state_d = StIdle;
            end else if (sel && din && !din_q) begin
               state_d  = StWait;
               write_d  = 1'b0;
               wait_d   = WaitInit;
               mem_rd_d = sel_ram;
            end else if (sel && dout && !dout_q) begin
               state_d = StWait;
               write_d = 1'b1;
               wait_d  = WaitInit;
            end
         end
         StWait: begin
            if (vec_q ? !din : !sync) begin
               state_d = StIdle;
            end else if (wait_q != 4'd0) begin
               wait_d = wait_q - 4'd1;
            end else if (!mem_rd_q) begin
               // RAM data is only captured one clk after the read strobe.
               state_d  = vec_q ? StVec : StReply;
               go_reply = 1'b1;
            end
         end
         StReply: begin
            if (!sync) state_d = StIdle;
            else if (write_q ? !dout : !din) state_d = StAddr;
         end
         StVec: begin
            if (!din) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign wr_fire  = go_reply && write_q;
   assign mem_wr_d = wr_fire && sel_ram;

   always_comb begin
      rdata_d = rdata_q;
      if (rd_valid_q) rdata_d = mem_rdata;
      else if (go_reply && !write_q && !vec_q && !sel_ram) rdata_d = reg_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         sync_q     <= 1'b0;
         din_q      <= 1'b0;
         dout_q     <= 1'b0;
         addr_q     <= 16'h0000;
         byte_q     <= 1'b0;
         write_q    <= 1'b0;
         vec_q      <= 1'b0;
         wait_q     <= 4'd0;
         mem_rd_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         mem_wr_q   <= 1'b0;
         rdata_q    <= 16'h0000;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync;
         din_q      <= din;
         dout_q     <= dout;
         addr_q     <= addr_d;
         byte_q     <= byte_d;
         write_q    <= write_d;
         vec_q      <= vec_d;
         wait_q     <= wait_d;
         mem_rd_q   <= mem_rd_d;
         rd_valid_q <= mem_rd_q;
         mem_wr_q   <= mem_wr_d;
         rdata_q    <= rdata_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_rq_q   <= 1'b0;
         evnt_rq_q   <= 1'b0;
         halt_en_q   <= 1'b0;
         hex_q       <= 16'h0000;
         rx_ie_q     <= 1'b0;
         tx_ie_q     <= 1'b0;
         tx_rdy_q    <= 1'b1;
         vec_taken_q <= 1'b0;
         tx_stb_q    <= 1'b0;
         tx_data_q   <= 8'h00;
         busy_q      <= 16'h0000;
      end else begin
         tx_stb_q <= 1'b0;
         if (wr_fire && sel_halt) begin
            if (wmask[0])  halt_rq_q <= ad_in[0];
            if (wmask[1])  evnt_rq_q <= ad_in[1];
            if (wmask[15]) halt_en_q <= ad_in[15];
         end
         if (wr_fire && sel_hex) hex_q <= (hex_q & ~wmask) | (ad_in & wmask);
         if (busy_q != 16'h0000) begin
            busy_q <= busy_q - 16'd1;
            if (busy_q == 16'd1) tx_rdy_q <= 1'b1;
         end
         if (go_reply && vec_q) vec_taken_q <= 1'b1;
         if (wr_fire && sel_rcsr && wmask[6]) rx_ie_q <= ad_in[6];
         if (wr_fire && sel_xcsr && wmask[6]) begin
            tx_ie_q     <= ad_in[6];
            vec_taken_q <= 1'b0;
         end
         // Placed last so a TX write overrides a busy timer expiring in the same clk.
         if (wr_fire && sel_xbuf && wmask[0]) begin
            tx_data_q   <= ad_in[7:0];
            tx_stb_q    <= 1'b1;
            tx_rdy_q    <= TxZero;
            busy_q      <= TxInit;
            vec_taken_q <= 1'b0;
         end
      end
   end

   assign rply     = (state_q == StReply) || (state_q == StVec);
   assign ad_oe    = ((state_q == StReply) && !write_q) || (state_q == StVec);
   assign ad_out   = (state_q == StVec) ? TTY_VECTOR : (ad_oe ? rdata_q : 16'h0000);
   assign virq     = TtyEn && tx_rdy_q && tx_ie_q && !vec_taken_q;
   assign mem_addr = addr_q[14:1];
   assign mem_rd   = mem_rd_q;
   assign mem_wr   = mem_wr_q;
   assign mem_be   = mem_wr_q ? be : (mem_rd_q ? 2'b11 : 2'b00);
   assign tx_data  = tx_data_q;
   assign tx_stb   = tx_stb_q;
   assign halt_rq  = halt_rq_q;
   assign evnt_rq  = evnt_rq_q;
   assign halt_en  = halt_en_q;
   assign hex_out  = hex_q;

endmodule

// File: tb/tb_vm3_qbus_slave.sv
// Directed bench for vm3_qbus_slave: one instance with no wait states, one with three.
// A small word RAM model answers both instances' read/write strobes.
module tb_vm3_qbus_slave;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sync = 1'b0, din = 1'b0, dout = 1'b0, wtbt = 1'b0, iako = 1'b0, sel3 = 1'b0;
   logic [15:0] ad_in = 16'h0000;
   int n_assert = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   logic sync0, din0, dout0, iako0, sync3, din3, dout3, iako3;
   assign sync0 = sync & ~sel3;
   assign din0  = din & ~sel3;
   assign dout0 = dout & ~sel3;
   assign iako0 = iako & ~sel3;
   assign sync3 = sync & sel3;
   assign din3  = din & sel3;
   assign dout3 = dout & sel3;
   assign iako3 = iako & sel3;

   logic [15:0] ad_out0, ad_out3, rdata0, rdata3, hex_out0, hex_out3;
   logic        ad_oe0, ad_oe3, rply0, rply3, virq0, virq3, mem_rd0, mem_rd3, mem_wr0, mem_wr3;
   logic [13:0] mem_addr0, mem_addr3;
   logic [1:0]  mem_be0, mem_be3;
   logic [7:0]  tx_data0, tx_data3;
   logic        tx_stb0, tx_stb3, halt_rq0, halt_rq3, evnt_rq0, evnt_rq3, halt_en0, halt_en3;

   vm3_qbus_slave #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .sync(sync0), .din(din0), .dout(dout0), .wtbt(wtbt), .iako(iako0),
      .ad_in(ad_in), .ad_out(ad_out0), .ad_oe(ad_oe0), .rply(rply0), .virq(virq0),
      .mem_addr(mem_addr0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_be(mem_be0),
      .mem_rdata(rdata0), .tx_data(tx_data0), .tx_stb(tx_stb0), .halt_rq(halt_rq0),
      .evnt_rq(evnt_rq0), .halt_en(halt_en0), .hex_out(hex_out0)
   );

   vm3_qbus_slave #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .sync(sync3), .din(din3), .dout(dout3), .wtbt(wtbt), .iako(iako3),
      .ad_in(ad_in), .ad_out(ad_out3), .ad_oe(ad_oe3), .rply(rply3), .virq(virq3),
      .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_be(mem_be3),
      .mem_rdata(rdata3), .tx_data(tx_data3), .tx_stb(tx_stb3), .halt_rq(halt_rq3),
      .evnt_rq(evnt_rq3), .halt_en(halt_en3), .hex_out(hex_out3)
   );

   logic [15:0] ad_out_m;
   logic        rply_m, ad_oe_m, mem_wr_m, tx_stb_m;
   logic [1:0]  mem_be_m;
   assign ad_out_m = sel3 ? ad_out3 : ad_out0;
   assign rply_m   = sel3 ? rply3 : rply0;
   assign ad_oe_m  = sel3 ? ad_oe3 : ad_oe0;
   assign mem_wr_m = sel3 ? mem_wr3 : mem_wr0;
   assign mem_be_m = sel3 ? mem_be3 : mem_be0;
   assign tx_stb_m = sel3 ? tx_stb3 : tx_stb0;

   logic [15:0] ram [0:255];
   always @(posedge clk) begin
      if (mem_wr0 && mem_be0[0]) ram[mem_addr0[7:0]][7:0]  <= ad_in[7:0];
      if (mem_wr0 && mem_be0[1]) ram[mem_addr0[7:0]][15:8] <= ad_in[15:8];
      if (mem_wr3 && mem_be3[0]) ram[mem_addr3[7:0]][7:0]  <= ad_in[7:0];
      if (mem_wr3 && mem_be3[1]) ram[mem_addr3[7:0]][15:8] <= ad_in[15:8];
      if (mem_rd0) rdata0 <= ram[mem_addr0[7:0]];
      if (mem_rd3) rdata3 <= ram[mem_addr3[7:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] a, input logic w);
      @(posedge clk); #1;
      ad_in = a; wtbt = w; sync = 1'b1;
      @(posedge clk); #1;
      wtbt = 1'b0;
   endtask

   task automatic bus_end();
      sync = 1'b0; ad_in = 16'h0000;
      @(posedge clk); #1;
   endtask

   // lat counts clk edges after the edge that first samples the strobe (64 = no reply).
   task automatic read_phase(output logic [15:0] data, output int lat, output logic oe,
                             output logic drop);
      din = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!rply_m && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      data = ad_out_m; oe = ad_oe_m;
      din = 1'b0;
      @(posedge clk); #1;
      drop = !rply_m && !ad_oe_m;
   endtask

   task automatic write_phase(input logic [15:0] data, output int lat, output logic wr1,
                              output logic [1:0] be, output logic stb, output logic wr2,
                              output logic drop);
      ad_in = data; dout = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!rply_m && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      wr1 = mem_wr_m; be = mem_be_m; stb = tx_stb_m;
      @(posedge clk); #1;
      wr2 = mem_wr_m | tx_stb_m;
      dout = 1'b0;
      @(posedge clk); #1;
      drop = !rply_m;
   endtask

   logic [15:0] d;
   int          lat, n;
   logic        oe, drop, wr1, wr2, stb;
   logic [1:0]  be;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl0", {rply0, ad_oe0, virq0, mem_rd0, mem_wr0, mem_be0, tx_stb0, halt_rq0,
                         evnt_rq0, halt_en0}, 32'h0);
      check("rst_bus0", {ad_out0, hex_out0}, 32'h0);
      check("rst_mem0", {mem_addr0, tx_data0}, 32'h0);
      check("rst_dut3", {rply3, ad_oe3, virq3, mem_rd3, mem_wr3, mem_be3, tx_stb3, halt_rq3,
                         evnt_rq3, halt_en3, tx_data3, mem_addr3[5:0]}, 32'h0);
      check("rst_bus3", {ad_out3, hex_out3}, 32'h0);
      rst = 1'b0;

      // Word write then read, no wait states
      start(16'o001000, 1'b0);
      write_phase(16'o123456, lat, wr1, be, stb, wr2, drop);
      check("w1_wr", wr1, 1'b1);
      check("w1_be", be, 2'b11);
      check("w1_wr_1clk", wr2, 1'b0);
      check("w1_drop", drop, 1'b1);
      bus_end();
      start(16'o001000, 1'b0);
      read_phase(d, lat, oe, drop);
      check("r1_data", d, 16'o123456);
      check("r1_lat", lat, 2);
      check("r1_oe", oe, 1'b1);
      check("r1_drop", drop, 1'b1);
      bus_end();

      // Byte write into the high byte
      start(16'o000002, 1'b0);
      write_phase(16'h1234, lat, wr1, be, stb, wr2, drop);
      bus_end();
      start(16'o000003, 1'b1);
      write_phase(16'hAB00, lat, wr1, be, stb, wr2, drop);
      check("b_wr", wr1, 1'b1);
      check("b_be", be, 2'b10);
      bus_end();
      start(16'o000002, 1'b0);
      read_phase(d, lat, oe, drop);
      check("b_data", d, 16'hAB34);
      bus_end();

      // Read-modify-write under one SYNC
      start(16'o000002, 1'b0);
      read_phase(d, lat, oe, drop);
      check("rmw_rd", d, 16'hAB34);
      write_phase(16'h5555, lat, wr1, be, stb, wr2, drop);
      check("rmw_wr", wr1, 1'b1);
      bus_end();
      start(16'o000002, 1'b0);
      read_phase(d, lat, oe, drop);
      check("rmw_data", d, 16'h5555);
      bus_end();

      // Three wait states
      sel3 = 1'b1;
      start(16'o001000, 1'b0);
      read_phase(d, lat, oe, drop);
      check("w3_lat", lat, 4);
      check("w3_data", d, 16'o123456);
      check("w3_drop", drop, 1'b1);
      bus_end();
      sel3 = 1'b0;

`ifdef VM3_QBUS_SLAVE_TTY_EN
      start(16'o177564, 1'b0);
      write_phase(16'o000100, lat, wr1, be, stb, wr2, drop);
      check("tx_ie_lat", lat, 1);
      bus_end();
      check("virq_ie", virq0, 1'b1);
      start(16'o177566, 1'b0);
      write_phase(16'o000101, lat, wr1, be, stb, wr2, drop);
      check("tx_stb", stb, 1'b1);
      check("tx_stb_1clk", wr2, 1'b0);
      check("tx_data", tx_data0, 8'h41);
      check("virq_busy", virq0, 1'b0);
      bus_end();
      n = 3;
      while (!virq0 && n < 700) begin
         @(posedge clk); #1;
         n++;
      end
      check("tx_delay", n, 500);
      start(16'o177564, 1'b0);
      read_phase(d, lat, oe, drop);
      check("xcsr_rd", d, 16'o000300);
      bus_end();
      iako = 1'b1;
      read_phase(d, lat, oe, drop);
      iako = 1'b0;
      check("vec_data", d, 16'o000064);
      check("vec_oe", oe, 1'b1);
      check("vec_lat", lat, 1);
      check("vec_drop", drop, 1'b1);
      check("virq_taken", virq0, 1'b0);
`else
      start(16'o177564, 1'b0);
      write_phase(16'o000100, lat, wr1, be, stb, wr2, drop);
      check("tty_unsel", lat, 64);
      bus_end();
      check("virq_off", virq0, 1'b0);
      iako = 1'b1;
      read_phase(d, lat, oe, drop);
      iako = 1'b0;
      check("iako_off", lat, 64);
      check("iako_oe", oe, 1'b0);
`endif

      // Unselected address never replies; SYNC fall recovers
      start(16'o160000, 1'b0);
      read_phase(d, lat, oe, drop);
      check("unsel_lat", lat, 64);
      check("unsel_oe", oe, 1'b0);
      bus_end();
      start(16'o000002, 1'b0);
      read_phase(d, lat, oe, drop);
      check("recover", d, 16'h5555);
      bus_end();

      // Halt/outhex registers, then reset in the middle of a DIN
      start(16'o177710, 1'b0);
      write_phase(16'o100003, lat, wr1, be, stb, wr2, drop);
      bus_end();
      check("halt_bits", {halt_en0, evnt_rq0, halt_rq0}, 3'b111);
      start(16'o177710, 1'b0);
      read_phase(d, lat, oe, drop);
      check("halt_rd", d, 16'o100003);
      bus_end();
      start(16'o177714, 1'b0);
      write_phase(16'hBEEF, lat, wr1, be, stb, wr2, drop);
      bus_end();
      check("hex_out", hex_out0, 16'hBEEF);
      start(16'o177714, 1'b0);
      din = 1'b1;
      n = 0;
      while (!rply0 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      check("rst_pre_rply", {rply0, ad_out0}, {1'b1, 16'hBEEF});
      rst = 1'b1;
      #1;
      check("rst_async", {rply0, ad_oe0}, 2'b00);
      check("rst_regs", {halt_en0, evnt_rq0, halt_rq0, hex_out0}, 19'h0);
      din = 1'b0; sync = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
